// File: rtl/panel_arr_scanner_pkg.sv
// panel_arr_scanner_pkg: scan FSM encoding, field widths and word-to-field bit positions
package panel_arr_scanner_pkg;
    typedef enum logic [1:0] {ST_GAP, ST_LOAD, ST_SHIFT, ST_COMMIT} scan_state_t;
    localparam int NUM_LINES = 4;
    localparam int WORD_W = 16;
    localparam int REG_C_W = 31;
    localparam int STRT_W = 12;
    localparam int SEL_W = 12;
    // reg_c = {line1[14:0], line0}; strt = {line3[7:0], line2[15:12]}; sel = line2[11:0]
    localparam int REG_C_HI_W = REG_C_W - WORD_W;
    localparam int STRT_LO_W = WORD_W - SEL_W;
    localparam int STRT_HI_W = STRT_W - STRT_LO_W;
    localparam int LINE_REG_C_LO = 0;
    localparam int LINE_REG_C_HI = 1;
    localparam int LINE_SEL = 2;
    localparam int LINE_STRT_HI = 3;
    typedef struct packed {
        logic [REG_C_W-1:0] reg_c;
        logic [STRT_W-1:0] strt;
        logic [SEL_W-1:0] sel;
    } arr_snap_t;
endpackage

// File: rtl/hc165_shifter.sv
// hc165_shifter: pl_n/srclk timing for four 74HC165 chains and their 16-bit MSB-first shift registers
module hc165_shifter
    import panel_arr_scanner_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               start,
    input  logic [NUM_LINES-1:0]               ser_in,
    output logic                               pl_n,
    output logic                               srclk,
    output logic                               load_done,
    output logic                               shift_done,
    output logic [NUM_LINES-1:0][WORD_W-1:0]   words
);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    logic [7:0] div_cnt;
    logic [3:0] bit_cnt;
    logic shifting;
    logic div_end;
    assign div_end = div_cnt == DIV_LAST;
    assign load_done = !pl_n && div_end;
    assign shift_done = shifting && srclk && div_end && bit_cnt == 4'd15;
    // Data is sampled on the last low cycle, just before the rising srclk shifts the chain
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pl_n <= 1'b1;
            srclk <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shifting <= 1'b0;
            words <= '0;
        end else if (start) begin
            pl_n <= 1'b0;
            div_cnt <= '0;
        end else if (!pl_n) begin
            div_cnt <= div_end ? 8'd0 : div_cnt + 8'd1;
            if (div_end) begin
                pl_n <= 1'b1;
                shifting <= 1'b1;
                bit_cnt <= '0;
            end
        end else if (shifting) begin
            div_cnt <= div_end ? 8'd0 : div_cnt + 8'd1;
            if (div_end) begin
                srclk <= !srclk;
                if (!srclk)
                    for (int i = 0; i < NUM_LINES; i++)
                        words[i] <= {words[i][WORD_W-2:0], ser_in[i]};
                else begin
                    shifting <= bit_cnt != 4'd15;
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
        end
    end
endmodule

// File: rtl/panel_arr_scanner.sv
// panel_arr_scanner: periodic 74HC165 panel scan with freezable committed outputs.
// Define PNL_SCAN_DEBOUNCE_EN to commit only when two consecutive raw snapshots match.
module panel_arr_scanner
    import panel_arr_scanner_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int SCAN_GAP = 1024
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ser_in_0,
    input  logic               ser_in_1,
    input  logic               ser_in_2,
    input  logic               ser_in_3,
    output logic               pl_n,
    output logic               srclk,
    input  logic               freeze,
    output logic [REG_C_W-1:0] arr_reg_c_value,
    output logic [STRT_W-1:0]  arr_strt_value,
    output logic [SEL_W-1:0]   arr_sel_value,
    output logic               arr_valid,
    output logic               scan_done
);
    localparam logic [15:0] GAP_LAST = 16'(SCAN_GAP - 1);
    scan_state_t state, state_nx;
    logic [15:0] gap_cnt;
    logic start, load_done, shift_done, commit, accept;
    logic [NUM_LINES-1:0][WORD_W-1:0] words;
    arr_snap_t snap;
    logic unused_bits;

    hc165_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .ser_in     ({ser_in_3, ser_in_2, ser_in_1, ser_in_0}),
        .pl_n       (pl_n),
        .srclk      (srclk),
        .load_done  (load_done),
        .shift_done (shift_done),
        .words      (words)
    );

    always_comb begin
        state_nx = state;
        start = 1'b0;
        case (state)
            ST_GAP: if (gap_cnt == GAP_LAST) begin
                state_nx = ST_LOAD;
                start = 1'b1;
            end
            ST_LOAD: if (load_done) state_nx = ST_SHIFT;
            ST_SHIFT: if (shift_done) state_nx = ST_COMMIT;
            default: state_nx = ST_GAP;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_GAP;
            gap_cnt <= '0;
        end else begin
            state <= state_nx;
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 16'd1 : '0;
        end
    end

    assign snap = {words[LINE_REG_C_HI][REG_C_HI_W-1:0], words[LINE_REG_C_LO],
                   words[LINE_STRT_HI][STRT_HI_W-1:0], words[LINE_SEL][WORD_W-1:SEL_W],
                   words[LINE_SEL][SEL_W-1:0]};
    assign unused_bits = ^{words[LINE_REG_C_HI][WORD_W-1:REG_C_HI_W],
                           words[LINE_STRT_HI][WORD_W-1:STRT_HI_W]};
    assign commit = state == ST_COMMIT;

`ifdef PNL_SCAN_DEBOUNCE_EN
    arr_snap_t prev_snap;
    logic prev_vld;
    assign accept = prev_vld && snap == prev_snap;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_snap <= '0;
            prev_vld <= 1'b0;
        end else if (commit) begin
            prev_snap <= snap;
            prev_vld <= 1'b1;
        end
    end
`else
    assign accept = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arr_reg_c_value <= '0;
            arr_strt_value <= '0;
            arr_sel_value <= '0;
            arr_valid <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= commit && accept;
            if (commit && accept && !freeze) begin
                arr_reg_c_value <= snap.reg_c;
                arr_strt_value <= snap.strt;
                arr_sel_value <= snap.sel;
                arr_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_panel_arr_scanner.sv
// tb_panel_arr_scanner: 74HC165 chain model plus scoreboard of expected commits per scan
module tb_panel_arr_scanner;
    localparam int CLK_DIV = 1;
    localparam int SCAN_GAP = 4;
    localparam int PERIOD = SCAN_GAP + CLK_DIV + 32 * CLK_DIV + 1;
`ifdef PNL_SCAN_DEBOUNCE_EN
    localparam int SETTLE = 2;
`else
    localparam int SETTLE = 1;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic freeze = 1'b0;
    logic ser_in_0, ser_in_1, ser_in_2, ser_in_3;
    logic pl_n, srclk, arr_valid, scan_done;
    logic [30:0] arr_reg_c_value;
    logic [11:0] arr_strt_value, arr_sel_value;

    logic [30:0] sw_reg = '0;
    logic [11:0] sw_strt = '0, sw_sel = '0;
    logic sw_ub1 = 1'b0;
    logic [7:0] sw_ub3 = '0;
    logic [15:0] sr [4];

    typedef struct {
        logic done;
        logic [30:0] reg_c;
        logic [11:0] strt;
        logic [11:0] sel;
        logic valid;
    } exp_t;
    exp_t q[$];
    logic [30:0] m_reg = '0;
    logic [11:0] m_strt = '0, m_sel = '0;
    logic m_valid = 1'b0;
`ifdef PNL_SCAN_DEBOUNCE_EN
    logic [54:0] p_snap = '0;
    logic have_prev = 1'b0;
`endif
    int checks = 0;
    int errors = 0;
    int scans_seen = 0;

    panel_arr_scanner #(.CLK_DIV(CLK_DIV), .SCAN_GAP(SCAN_GAP)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ser_in_0        (ser_in_0),
        .ser_in_1        (ser_in_1),
        .ser_in_2        (ser_in_2),
        .ser_in_3        (ser_in_3),
        .pl_n            (pl_n),
        .srclk           (srclk),
        .freeze          (freeze),
        .arr_reg_c_value (arr_reg_c_value),
        .arr_strt_value  (arr_strt_value),
        .arr_sel_value   (arr_sel_value),
        .arr_valid       (arr_valid),
        .scan_done       (scan_done)
    );

    always #5 clk = ~clk;

    // Switch chains: parallel load while pl_n is low, shift toward Q7 on srclk rise
    always @(negedge pl_n or posedge srclk) begin
        if (!pl_n) begin
            sr[0] = sw_reg[15:0];
            sr[1] = {sw_ub1, sw_reg[30:16]};
            sr[2] = {sw_strt[3:0], sw_sel};
            sr[3] = {sw_ub3, sw_strt[11:4]};
        end else
            for (int i = 0; i < 4; i++) sr[i] = {sr[i][14:0], 1'b0};
    end
    assign ser_in_0 = sr[0][15];
    assign ser_in_1 = sr[1][15];
    assign ser_in_2 = sr[2][15];
    assign ser_in_3 = sr[3][15];

    task automatic scoreboard();
        exp_t e;
        int nfall = 0;
        logic upd;
        forever begin
            @(negedge pl_n or negedge srclk or negedge resetn);
            if (!resetn) begin
                q.delete();
                nfall = 0;
                m_reg = '0;
                m_strt = '0;
                m_sel = '0;
                m_valid = 1'b0;
`ifdef PNL_SCAN_DEBOUNCE_EN
                have_prev = 1'b0;
`endif
            end else if (!pl_n) begin
`ifdef PNL_SCAN_DEBOUNCE_EN
                upd = have_prev && p_snap == {sw_reg, sw_strt, sw_sel};
                have_prev = 1'b1;
                p_snap = {sw_reg, sw_strt, sw_sel};
`else
                upd = 1'b1;
`endif
                if (upd && !freeze) begin
                    m_reg = sw_reg;
                    m_strt = sw_strt;
                    m_sel = sw_sel;
                    m_valid = 1'b1;
                end
                q.push_back('{upd, m_reg, m_strt, m_sel, m_valid});
            end else begin
                nfall++;
                if (nfall == 16) begin
                    nfall = 0;
                    @(posedge clk);
                    #1;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: scan ended with no expectation queued");
                    end else begin
                        e = q.pop_front();
                        checks++;
                        if (scan_done !== e.done) begin
                            errors++;
                            $display("FAIL sb_scan_done: got %b expected %b", scan_done, e.done);
                        end
                        checks++;
                        if (arr_reg_c_value !== e.reg_c) begin
                            errors++;
                            $display("FAIL sb_reg_c: got %o expected %o", arr_reg_c_value, e.reg_c);
                        end
                        checks++;
                        if (arr_strt_value !== e.strt) begin
                            errors++;
                            $display("FAIL sb_strt: got %o expected %o", arr_strt_value, e.strt);
                        end
                        checks++;
                        if (arr_sel_value !== e.sel) begin
                            errors++;
                            $display("FAIL sb_sel: got %o expected %o", arr_sel_value, e.sel);
                        end
                        checks++;
                        if (arr_valid !== e.valid) begin
                            errors++;
                            $display("FAIL sb_valid: got %b expected %b", arr_valid, e.valid);
                        end
                    end
                    scans_seen++;
                    @(posedge clk);
                    #1;
                    checks++;
                    if (scan_done !== 1'b0) begin
                        errors++;
                        $display("FAIL sb_pulse_width: scan_done got %b expected 0", scan_done);
                    end
                end
            end
        end
    endtask

    task automatic wait_scans(input int n);
        int target = scans_seen + n;
        for (int i = 0; i < (n + 4) * PERIOD && scans_seen < target; i++) @(posedge clk);
        checks++;
        if (scans_seen < target) begin
            errors++;
            $display("FAIL scan_timeout: got %0d scans expected %0d", scans_seen, target);
        end
    endtask

    task automatic cycles_to_pl_fall(output int n);
        logic last = pl_n;
        n = -1;
        for (int i = 1; i <= 3 * PERIOD; i++) begin
            @(posedge clk);
            #1;
            if (last && !pl_n) begin
                n = i;
                break;
            end
            last = pl_n;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pl_n !== 1'b1) begin errors++; $display("FAIL rst_pl_n: got %b expected 1", pl_n); end
        checks++; if (srclk !== 1'b0) begin errors++; $display("FAIL rst_srclk: got %b expected 0", srclk); end
        checks++; if (arr_reg_c_value !== 31'd0) begin errors++; $display("FAIL rst_reg_c: got %o expected 0", arr_reg_c_value); end
        checks++; if ({arr_strt_value, arr_sel_value} !== 24'd0) begin errors++; $display("FAIL rst_strt_sel: got %o expected 0", {arr_strt_value, arr_sel_value}); end
        checks++; if (arr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", arr_valid); end
        checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL rst_scan_done: got %b expected 0", scan_done); end
    endtask

    task automatic test_basic();
        sw_reg = 31'o12345670123;
        sw_strt = 12'o7654;
        sw_sel = 12'o0123;
        @(negedge clk);
        resetn = 1'b1;
        wait_scans(SETTLE);
        checks++; if (arr_reg_c_value !== 31'o12345670123) begin errors++; $display("FAIL basic_reg_c: got %o expected 12345670123", arr_reg_c_value); end
        checks++; if (arr_strt_value !== 12'o7654) begin errors++; $display("FAIL basic_strt: got %o expected 7654", arr_strt_value); end
        checks++; if (arr_sel_value !== 12'o0123) begin errors++; $display("FAIL basic_sel: got %o expected 0123", arr_sel_value); end
        checks++; if (arr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", arr_valid); end
    endtask

    task automatic test_period();
        int d;
        cycles_to_pl_fall(d);
        checks++; if (d < 0) begin errors++; $display("FAIL period_sync: no pl_n fall within %0d cycles", 3 * PERIOD); end
        for (int k = 0; k < 2; k++) begin
            cycles_to_pl_fall(d);
            checks++; if (d !== PERIOD) begin errors++; $display("FAIL pl_n_spacing: got %0d expected %0d", d, PERIOD); end
        end
    endtask

    task automatic test_freeze();
        wait_scans(1);
        freeze = 1'b1;
        sw_sel = 12'o7777;
        wait_scans(1);
        checks++; if (arr_sel_value !== 12'o0123) begin errors++; $display("FAIL freeze_hold: got %o expected 0123", arr_sel_value); end
        freeze = 1'b0;
        wait_scans(1);
        checks++; if (arr_sel_value !== 12'o7777) begin errors++; $display("FAIL freeze_release: got %o expected 7777", arr_sel_value); end
    endtask

    task automatic test_unused_bits();
        sw_ub1 = 1'b1;
        sw_ub3 = 8'hff;
        wait_scans(SETTLE);
        checks++; if (arr_reg_c_value !== 31'o12345670123) begin errors++; $display("FAIL unused_reg_c: got %o expected 12345670123", arr_reg_c_value); end
        checks++; if (arr_strt_value !== 12'o7654) begin errors++; $display("FAIL unused_strt: got %o expected 7654", arr_strt_value); end
        checks++; if (arr_sel_value !== 12'o7777) begin errors++; $display("FAIL unused_sel: got %o expected 7777", arr_sel_value); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            sw_reg = 31'($urandom());
            sw_strt = 12'($urandom());
            sw_sel = 12'($urandom());
            sw_ub1 = 1'($urandom());
            sw_ub3 = 8'($urandom());
            wait_scans(SETTLE);
            checks++;
            if ({arr_reg_c_value, arr_strt_value, arr_sel_value} !== {sw_reg, sw_strt, sw_sel}) begin
                errors++;
                $display("FAIL b2b_fields[%0d]: got %o/%o/%o expected %o/%o/%o", k,
                         arr_reg_c_value, arr_strt_value, arr_sel_value, sw_reg, sw_strt, sw_sel);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        int d;
        int nf = 0;
        logic last_s;
        cycles_to_pl_fall(d);
        last_s = srclk;
        for (int i = 0; i < 4 * PERIOD && nf < 7; i++) begin
            @(posedge clk);
            #1;
            if (last_s && !srclk) nf++;
            last_s = srclk;
        end
        checks++; if (nf != 7) begin errors++; $display("FAIL mid_sync: got %0d srclk falls expected 7", nf); end
        resetn = 1'b0;
        #1;
        checks++; if (pl_n !== 1'b1 || srclk !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl: got pl_n=%b srclk=%b expected 1/0", pl_n, srclk); end
        checks++; if ({arr_reg_c_value, arr_strt_value, arr_sel_value} !== 55'd0) begin errors++; $display("FAIL mid_rst_fields: got %o expected 0", {arr_reg_c_value, arr_strt_value, arr_sel_value}); end
        checks++; if (arr_valid !== 1'b0 || scan_done !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got valid=%b done=%b expected 0/0", arr_valid, scan_done); end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        cycles_to_pl_fall(d);
        checks++; if (d !== SCAN_GAP) begin errors++; $display("FAIL mid_first_load: got %0d cycles expected %0d", d, SCAN_GAP); end
        checks++; if (arr_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_hold: got %b expected 0", arr_valid); end
        wait_scans(SETTLE);
    endtask

`ifdef PNL_SCAN_DEBOUNCE_EN
    task automatic test_debounce();
        @(negedge clk);
        resetn = 1'b0;
        sw_reg = 31'o1;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_scans(1);
            checks++; if (arr_valid !== 1'b0) begin errors++; $display("FAIL deb_toggle_valid[%0d]: got %b expected 0", i, arr_valid); end
            sw_reg = i[0] ? 31'o2 : 31'o2 - 31'd1 + 31'd1;
            sw_reg = (i % 2 == 0) ? 31'o2 : 31'o1;
        end
        wait_scans(1);
        checks++; if (arr_valid !== 1'b0) begin errors++; $display("FAIL deb_first_hold: got %b expected 0", arr_valid); end
        wait_scans(1);
        checks++; if (arr_valid !== 1'b1) begin errors++; $display("FAIL deb_match_valid: got %b expected 1", arr_valid); end
        checks++; if (arr_reg_c_value !== 31'o2) begin errors++; $display("FAIL deb_match_reg_c: got %o expected 2", arr_reg_c_value); end
    endtask
`endif

    initial begin
        fork
            scoreboard();
        join_none
        test_reset();
        test_basic();
        test_period();
        test_freeze();
        test_unused_bits();
        test_back_to_back();
        test_reset_mid_shift();
`ifdef PNL_SCAN_DEBOUNCE_EN
        test_debounce();
`endif
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d queued expectations expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
